// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target controller.
package i2c_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      ADDR_ACK,
      WR_DATA,
      WR_ACK,
      RD_DATA,
      RD_ACK,
      WAIT_STOP
   } i2c_slv_state_t;

   localparam logic        I2C_ACK           = 1'b0;
   localparam logic        I2C_NACK          = 1'b1;
   localparam int unsigned I2C_BITS_PER_BYTE = 8;

   // Bit-counter values for the last bit of a byte and for a full byte.
   localparam logic [3:0]  I2C_LAST_BIT      = 4'(I2C_BITS_PER_BYTE - 1);
   localparam logic [3:0]  I2C_FULL_BYTE     = 4'(I2C_BITS_PER_BYTE);

endpackage

// File: rtl/i2c_line_sync.sv
// SCL/SDA synchronizer with edge, START and STOP detection.
module i2c_line_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic scl,
   input  logic sda,
   output logic scl_s,
   output logic sda_s,
   output logic scl_rise,
   output logic scl_fall,
   output logic start_cond,
   output logic stop_cond
);

   logic [SYNC_STAGES-1:0] r_scl_sync;
   logic [SYNC_STAGES-1:0] r_sda_sync;
   logic                   r_scl_d;
   logic                   r_sda_d;

   // Synchronizer chains plus one delayed copy; reset to the idle-bus level (high)
   // so reset release never fakes an edge or a bus condition.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_scl_sync <= '1;
         r_sda_sync <= '1;
         r_scl_d    <= 1'b1;
         r_sda_d    <= 1'b1;
      end else begin
         r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl};
         r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda};
         r_scl_d    <= r_scl_sync[SYNC_STAGES-1];
         r_sda_d    <= r_sda_sync[SYNC_STAGES-1];
      end
   end

   assign scl_s      = r_scl_sync[SYNC_STAGES-1];
   assign sda_s      = r_sda_sync[SYNC_STAGES-1];
   assign scl_rise   = scl_s & ~r_scl_d;
   assign scl_fall   = ~scl_s & r_scl_d;
   // SDA may only change while SCL is high for a bus condition.
   assign start_cond = scl_s & r_scl_d & r_sda_d & ~sda_s;
   assign stop_cond  = scl_s & r_scl_d & ~r_sda_d & sda_s;

endmodule

// File: rtl/i2c_slave_ctrl.sv
// I2C target: 7-bit address match, byte write/read, open-drain SDA driver.
module i2c_slave_ctrl
   import i2c_pkg::*;
#(
   parameter logic [6:0]  SLAVE_ADDR  = 7'h10,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       i2c_scl,
   inout  wire        i2c_sda,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic [7:0] tx_data,
   output logic       tx_req,
   output logic       busy,
   output logic       rw_dir
);

   logic           w_scl_s;
   logic           w_sda_s;
   logic           w_scl_rise;
   logic           w_scl_fall;
   logic           w_start;
   logic           w_stop;
   logic           w_sample;

   i2c_slv_state_t r_state;
   logic [3:0]     r_bit_cnt;
   logic [6:0]     r_shift;
   logic           r_sda_oe;
   logic           r_rd_load;
   logic [7:0]     r_rx_data;
   logic           r_rx_valid;
   logic           r_tx_req;
   logic           r_busy;
   logic           r_rw_dir;

   i2c_line_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_line_sync (
      .clk        (clk),
      .reset      (reset),
      .scl        (i2c_scl),
      .sda        (i2c_sda),
      .scl_s      (w_scl_s),
      .sda_s      (w_sda_s),
      .scl_rise   (w_scl_rise),
      .scl_fall   (w_scl_fall),
      .start_cond (w_start),
      .stop_cond  (w_stop)
   );

   assign w_sample = w_scl_rise & w_scl_s;

   // Protocol FSM; bus conditions override every state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= IDLE;
         r_bit_cnt  <= '0;
         r_shift    <= '0;
         r_sda_oe   <= 1'b0;
         r_rd_load  <= 1'b0;
         r_rx_data  <= '0;
         r_rx_valid <= 1'b0;
         r_tx_req   <= 1'b0;
         r_busy     <= 1'b0;
         r_rw_dir   <= 1'b0;
      end else begin
         r_rx_valid <= 1'b0;
         r_tx_req   <= 1'b0;
         if (w_start) begin
            r_state   <= ADDR;
            r_bit_cnt <= '0;
            r_busy    <= 1'b0;
            r_sda_oe  <= 1'b0;
            r_rd_load <= 1'b0;
         end else if (w_stop) begin
            r_state   <= IDLE;
            r_bit_cnt <= '0;
            r_busy    <= 1'b0;
            r_sda_oe  <= 1'b0;
            r_rd_load <= 1'b0;
         end else begin
            case (r_state)
               IDLE: ;
               ADDR: begin
                  if (w_sample) begin
                     r_shift <= {r_shift[5:0], w_sda_s};
                     if (r_bit_cnt == I2C_LAST_BIT) begin
                        r_bit_cnt <= '0;
                        if (r_shift == SLAVE_ADDR) begin
                           r_state  <= ADDR_ACK;
                           r_busy   <= 1'b1;
                           r_rw_dir <= w_sda_s;
                           r_tx_req <= w_sda_s;
                        end else begin
                           r_state <= WAIT_STOP;
                        end
                     end else begin
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                     end
                  end
               end
               // Count 0: waiting for the fall that opens the ACK slot; 1: ACK driven.
               ADDR_ACK, WR_ACK: begin
                  if (w_scl_fall) begin
                     if (r_bit_cnt == 4'd0) begin
                        r_sda_oe  <= ~I2C_ACK;
                        r_bit_cnt <= 4'd1;
                     end else begin
                        r_bit_cnt <= '0;
                        if (r_state == ADDR_ACK && r_rw_dir) begin
                           r_state  <= RD_DATA;
                           r_shift  <= tx_data[6:0];
                           r_sda_oe <= ~tx_data[7];
                        end else begin
                           r_state  <= WR_DATA;
                           r_sda_oe <= 1'b0;
                        end
                     end
                  end
               end
               WR_DATA: begin
                  if (w_sample) begin
                     r_shift <= {r_shift[5:0], w_sda_s};
                     if (r_bit_cnt == I2C_LAST_BIT) begin
                        r_rx_data  <= {r_shift, w_sda_s};
                        r_rx_valid <= 1'b1;
                        r_state    <= WR_ACK;
                        r_bit_cnt  <= '0;
                     end else begin
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                     end
                  end
               end
               // r_rd_load: entered from RD_ACK, next fall loads the fresh tx_data.
               RD_DATA: begin
                  if (w_scl_fall) begin
                     if (r_rd_load) begin
                        r_rd_load <= 1'b0;
                        r_shift   <= tx_data[6:0];
                        r_sda_oe  <= ~tx_data[7];
                     end else if (r_bit_cnt == I2C_FULL_BYTE) begin
                        r_sda_oe  <= 1'b0;
                        r_state   <= RD_ACK;
                        r_bit_cnt <= '0;
                     end else begin
                        r_shift  <= {r_shift[5:0], 1'b0};
                        r_sda_oe <= ~r_shift[6];
                     end
                  end else if (w_sample && !r_rd_load && r_bit_cnt != I2C_FULL_BYTE) begin
                     r_bit_cnt <= r_bit_cnt + 4'd1;
                  end
               end
               RD_ACK: begin
                  if (w_sample) begin
                     r_bit_cnt <= '0;
                     if (w_sda_s == I2C_ACK) begin
                        r_tx_req  <= 1'b1;
                        r_rd_load <= 1'b1;
                        r_state   <= RD_DATA;
                     end else begin
                        r_state <= WAIT_STOP;
                     end
                  end
               end
               WAIT_STOP: r_sda_oe <= 1'b0;
               default: begin
                  r_state  <= IDLE;
                  r_sda_oe <= 1'b0;
               end
            endcase
         end
      end
   end

   assign i2c_sda  = r_sda_oe ? 1'b0 : 1'bz;
   assign rx_data  = r_rx_data;
   assign rx_valid = r_rx_valid;
   assign tx_req   = r_tx_req;
   assign busy     = r_busy;
   assign rw_dir   = r_rw_dir;

endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// Scoreboard bench for i2c_slave_ctrl: bus-master tasks plus rx/tx monitors.
module tb_i2c_slave_ctrl;

   localparam int H = 100;  // half SCL period (10 clk)
   localparam int Q = 50;

   logic       clk = 1'b0;
   logic       reset;
   logic       m_scl;
   logic       m_sda_low;
   wire        i2c_sda;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic [7:0] tx_data;
   logic       tx_req;
   logic       busy;
   logic       rw_dir;

   int n_tests = 0;
   int n_fail  = 0;
   int rx_cnt  = 0;
   int txreq_cnt = 0;

   logic [7:0] exp_rx[$];
   logic [7:0] exp_rd[$];
   logic [7:0] tx_plan[$];
   logic [7:0] wr_buf[8];
   logic [7:0] mon_v;

   assign i2c_sda = m_sda_low ? 1'b0 : 1'bz;
   pullup (i2c_sda);

   always #5 clk = ~clk;

   i2c_slave_ctrl #(
      .SLAVE_ADDR  (7'h10),
      .SYNC_STAGES (2)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .i2c_scl  (m_scl),
      .i2c_sda  (i2c_sda),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .tx_data  (tx_data),
      .tx_req   (tx_req),
      .busy     (busy),
      .rw_dir   (rw_dir)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: pops expected write bytes on rx_valid, serves tx_data on tx_req.
   always @(negedge clk) begin
      if (!reset) begin
         if (rx_valid) begin
            rx_cnt++;
            if (exp_rx.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL rx_unexpected: got 0x%0h expected no rx_valid", rx_data);
            end else begin
               check("rx_data", {24'h0, rx_data}, {24'h0, exp_rx.pop_front()});
            end
         end
         if (tx_req) begin
            txreq_cnt++;
            if (tx_plan.size() != 0) mon_v = tx_plan.pop_front();
            else mon_v = 8'($urandom);
            tx_data = mon_v;
            exp_rd.push_back(mon_v);
         end
      end
   end

   task automatic bus_start();
      m_sda_low = 1'b0;
      #Q m_scl = 1'b1;
      #H m_sda_low = 1'b1;
      #H m_scl = 1'b0;
      #Q;
   endtask

   task automatic bus_stop();
      m_sda_low = 1'b1;
      #Q m_scl = 1'b1;
      #H m_sda_low = 1'b0;
      #H;
   endtask

   task automatic send_bit(input logic b);
      m_sda_low = ~b;
      #Q m_scl = 1'b1;
      #H m_scl = 1'b0;
      #Q;
   endtask

   task automatic recv_bit(output logic b);
      m_sda_low = 1'b0;
      #Q m_scl = 1'b1;
      #(H/2) b = (i2c_sda === 1'b0) ? 1'b0 : 1'b1;
      #(H/2) m_scl = 1'b0;
      #Q;
   endtask

   task automatic send_byte(input logic [7:0] d, output logic ack);
      for (int i = 7; i >= 0; i--) send_bit(d[i]);
      recv_bit(ack);
   endtask

   task automatic recv_byte(output logic [7:0] d);
      logic b;
      d = '0;
      for (int i = 0; i < 8; i++) begin
         recv_bit(b);
         d = {d[6:0], b};
      end
   endtask

   // Reference: only address 0x10 is acknowledged; each acked byte appears on rx.
   task automatic write_txn(input logic [6:0] addr, input int n, input bit do_stop);
      logic match;
      logic ack;
      match = (addr == 7'h10);
      bus_start();
      send_byte({addr, 1'b0}, ack);
      check("wr_addr_ack", {31'h0, ack}, match ? 32'h0 : 32'h1);
      #H;
      check("wr_busy", {31'h0, busy}, {31'h0, match});
      if (match) check("wr_rw_dir", {31'h0, rw_dir}, 32'h0);
      for (int i = 0; i < n; i++) begin
         if (match) exp_rx.push_back(wr_buf[i]);
         send_byte(wr_buf[i], ack);
         check("wr_data_ack", {31'h0, ack}, match ? 32'h0 : 32'h1);
      end
      if (do_stop) begin
         bus_stop();
         #H;
         check("busy_after_stop", {31'h0, busy}, 32'h0);
      end
   endtask

   // Reference: the master reads n bytes, ACKing all but the last; each byte equals
   // the tx_data served for one tx_req, so n requests are expected.
   task automatic read_txn(input logic [6:0] addr, input int n, input bit do_stop);
      logic       match;
      logic       ack;
      logic [7:0] d;
      int         base;
      match = (addr == 7'h10);
      base = txreq_cnt;
      bus_start();
      send_byte({addr, 1'b1}, ack);
      check("rd_addr_ack", {31'h0, ack}, match ? 32'h0 : 32'h1);
      if (match) begin
         check("rd_busy", {31'h0, busy}, 32'h1);
         check("rd_rw_dir", {31'h0, rw_dir}, 32'h1);
         for (int i = 0; i < n; i++) begin
            recv_byte(d);
            if (exp_rd.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL rd_byte: got 0x%0h expected a requested byte", d);
            end else begin
               check("rd_byte", {24'h0, d}, {24'h0, exp_rd.pop_front()});
            end
            send_bit(i == n - 1);
         end
         #Q;
         check("sda_released_after_nack", {31'h0, i2c_sda}, 32'h1);
         check("tx_req_count", txreq_cnt - base, n);
      end else begin
         check("tx_req_none", txreq_cnt - base, 0);
      end
      if (do_stop) begin
         bus_stop();
         #H;
         check("busy_after_stop", {31'h0, busy}, 32'h0);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int         base;
      logic       ack;
      logic [6:0] ra;
      reset     = 1'b1;
      m_scl     = 1'b1;
      m_sda_low = 1'b0;
      tx_data   = 8'h00;
      #15;
      check("reset_rx_data", {24'h0, rx_data}, 32'h0);
      check("reset_outputs", {28'h0, rx_valid, tx_req, busy, rw_dir}, 32'h0);
      check("reset_sda", {31'h0, i2c_sda}, 32'h1);
      #20 reset = 1'b0;
      #H;

      // Plain write of three bytes.
      base = rx_cnt;
      wr_buf[0] = 8'h00; wr_buf[1] = 8'hA5; wr_buf[2] = 8'h3C;
      write_txn(7'h10, 3, 1'b1);
      check("wr_rx_count", rx_cnt - base, 3);

      // Address mismatch: no ACK anywhere, no rx_valid.
      base = rx_cnt;
      wr_buf[0] = 8'hFF;
      write_txn(7'h11, 1, 1'b1);
      check("mismatch_rx_count", rx_cnt - base, 0);

      // Read two bytes, ACK then NACK.
      tx_plan.push_back(8'h5A);
      tx_plan.push_back(8'hC3);
      read_txn(7'h10, 2, 1'b1);

      // Repeated START: write then read.
      base = rx_cnt;
      wr_buf[0] = 8'h07;
      write_txn(7'h10, 1, 1'b0);
      read_txn(7'h10, 1, 1'b1);
      check("rs_rx_data", {24'h0, rx_data}, 32'h07);
      check("rs_rx_count", rx_cnt - base, 1);

      // STOP after 5 bits discards the partial byte.
      base = rx_cnt;
      bus_start();
      send_byte({7'h10, 1'b0}, ack);
      check("partial_addr_ack", {31'h0, ack}, 32'h0);
      for (int i = 0; i < 5; i++) send_bit(1'($urandom));
      bus_stop();
      #H;
      check("partial_busy", {31'h0, busy}, 32'h0);
      check("partial_rx_count", rx_cnt - base, 0);
      wr_buf[0] = 8'($urandom); wr_buf[1] = 8'($urandom);
      write_txn(7'h10, 2, 1'b1);
      check("after_partial_rx_count", rx_cnt - base, 2);

      // Reset while the target pulls SDA low in a read.
      tx_plan.push_back(8'h3C);
      bus_start();
      send_byte({7'h10, 1'b1}, ack);
      check("rst_addr_ack", {31'h0, ack}, 32'h0);
      check("rst_sda_driven", {31'h0, i2c_sda}, 32'h0);
      reset = 1'b1;
      #1;
      check("rst_sda_released", {31'h0, i2c_sda}, 32'h1);
      check("rst_outputs", {28'h0, rx_valid, tx_req, busy, rw_dir}, 32'h0);
      check("rst_rx_data", {24'h0, rx_data}, 32'h0);
      #20 reset = 1'b0;
      exp_rd.delete();
      bus_stop();
      wr_buf[0] = 8'($urandom);
      write_txn(7'h10, 1, 1'b1);

      // Randomized transactions.
      for (int k = 0; k < 10; k++) begin
         ra = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'h10;
         if ($urandom_range(0, 1) == 0) begin
            for (int i = 0; i < 8; i++) wr_buf[i] = 8'($urandom);
            write_txn(ra, $urandom_range(1, 4), 1'b1);
         end else begin
            read_txn(ra, $urandom_range(1, 3), 1'b1);
         end
      end

      #H;
      check("rx_queue_drained", exp_rx.size(), 0);
      check("rd_queue_drained", exp_rd.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/i2c_slave_ctrl.md
Name: i2c_slave_ctrl

Overview:
Synthesizable I2C target (slave) that answers the i2c_top master on the shared open-drain bus. It replaces the behavioural slave model in system builds.
- Oversamples SCL/SDA with the system clock.
- Detects START/STOP and matches a 7-bit address.
- Delivers written bytes to a local byte interface and serves read bytes from it.
- Standard-mode protocol; no clock stretching and no 10-bit addressing.

Parameters:
SLAVE_ADDR, 7'h10, 7-bit bus address this target acknowledges.
SYNC_STAGES, 2, synchronizer depth for SCL/SDA inputs (minimum 2).

Ports:
clk  input  1  system clock; every SCL high and low phase lasts at least 8 clk periods.
reset  input  1  asynchronous, active-high reset.
i2c_scl  input  1  bus clock, sampled only; this block never drives it.
i2c_sda  inout  1  bus data, open-drain; driven 0 or high-Z, never 1.
rx_data  output  8  last byte written by the master, MSB first as received.
rx_valid  output  1  one-clk pulse when rx_data is updated.
tx_data  input  8  byte to return on a master read.
tx_req  output  1  one-clk pulse requesting the next tx_data.
busy  output  1  high from address match until STOP or START.
rw_dir  output  1  R/W bit of the current matched transfer (1 = read).

Behaviour:
- Reset values: all outputs 0, SDA released (high-Z), state IDLE, bit counter 0.
- Reset has priority over any bus activity. Reset mid-transfer releases SDA immediately and ignores the rest of the transfer; the block rearms on the next START.
- Input path:
  - SCL and SDA pass through SYNC_STAGES flip-flops, then one registered copy for edge detection.
  - scl_rise, scl_fall, start_cond and stop_cond are one-clk pulses.
  - start_cond = SDA falls while SCL high; stop_cond = SDA rises while SCL high.
- Sampling: SDA is sampled on scl_rise. SDA output changes only on scl_fall, i.e. SYNC_STAGES+1 clk after the real SCL edge, which gives hold time.
- States:
  - IDLE: wait for start_cond.
  - ADDR: shift 8 bits on scl_rise (7 address bits then R/W).
    - Match -> ADDR_ACK, busy=1, rw_dir latched.
    - Mismatch -> WAIT_STOP, SDA never driven.
  - ADDR_ACK: drive SDA=0 from the scl_fall after bit 8 until the next scl_fall.
    - rw_dir=0 -> WR_DATA.
    - rw_dir=1 -> RD_DATA, with tx_req pulsed on entry to ADDR_ACK.
  - WR_DATA: shift 8 bits. On the 8th scl_rise: rx_data <= shift value, rx_valid pulses, -> WR_ACK.
  - WR_ACK: drive ACK exactly as in ADDR_ACK, then -> WR_DATA.
  - RD_DATA: tx_data is loaded into the shift register on the scl_fall that ends the ACK phase.
    - Each scl_fall drives the current MSB: SDA released for 1, pulled low for 0.
    - After 8 bits, SDA is released -> RD_ACK.
  - RD_ACK: sample master ACK on scl_rise.
    - ACK (0) -> pulse tx_req, -> RD_DATA.
    - NACK (1) -> WAIT_STOP.
  - WAIT_STOP: SDA released; wait for stop_cond or start_cond.
- start_cond in any state (repeated START): release SDA, bit counter = 0, busy=0, -> ADDR.
- stop_cond in any state: release SDA, busy=0, -> IDLE. A partial byte is discarded with no rx_valid.
- tx_data timing: must be stable within 4 clk after tx_req and held until the loading scl_fall.
- Bit counter: 4 bits, 0..8, cleared on every state entry. No wrap beyond 8.
- Arbitration: when the block releases SDA for a 1 and reads back 0, it does not check (single-master bus).

Decomposition:
- Package i2c_pkg:
  - state enum i2c_slv_state_t {IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP}.
  - I2C_ACK=1'b0, I2C_NACK=1'b1, I2C_BITS_PER_BYTE=8.
- Sub-module i2c_line_sync: synchronizer plus edge/START/STOP detector. Inputs: clk, reset, scl, sda. Outputs: scl_s, sda_s, scl_rise, scl_fall, start_cond, stop_cond.
- The top-level FSM, shift register and open-drain driver remain in i2c_slave_ctrl.

Test Plan:
- Write: START, addr 0x10 W, bytes 0x00/0xA5/0x3C, STOP -> ACK on all four 9th clocks; rx_valid pulses 3 times with rx_data 0x00, 0xA5, 0x3C; busy falls at STOP.
- Address mismatch: START, addr 0x11 W, byte 0xFF, STOP -> SDA never driven (NACK seen); no rx_valid; busy stays 0.
- Read: START, addr 0x10 R, tx_data 0x5A then 0xC3, master ACK then NACK -> bus carries 0x5A then 0xC3; exactly 2 tx_req pulses; SDA released after the NACK.
- Repeated START: write 0x10 W, data 0x07, Sr, 0x10 R, read 1 byte NACK, STOP -> rx_data=0x07; rw_dir goes 0->1; read returns tx_data.
- STOP after 5 bits of a write byte -> no rx_valid; state IDLE; next full write transaction accepted normally.
- reset asserted during RD_DATA while SDA is driven low -> SDA high-Z within one clk of reset assertion; outputs 0; after release, next START + 0x10 W is ACKed.
